// File: rtl/mem_stream_pkg.sv
// Shared definitions for the memory output stream: port geometry, mux select
// codes and the read-scheduler state/tag types.
package mem_stream_pkg;
  localparam int NPORT     = 12;
  localparam int NBITS_ENT = 6;
  localparam int PTR_W     = 4;

  localparam logic [3:0] SEL_IDLE = 4'b0000;
  localparam logic [3:0] SEL_HDR  = 4'b1111;

  typedef enum logic [1:0] {IDLE, HEADER, READ} state_t;

  typedef struct packed {
    logic [3:0] sel;
    logic [2:0] bx;
  } tag_t;

  // The mux reserves 1010 and 1110, so ports 9..11 step over 1010.
  function automatic logic [3:0] port_to_sel(input logic [PTR_W-1:0] p);
    if (p < 4'd9)       return p + 4'd1;
    else if (p < 4'd12) return p + 4'd2;
    else                return SEL_IDLE;
  endfunction
endpackage

// File: rtl/mem_read_sched_if.sv
// Control/stream bundle between the BX sequencer, the scheduler and the mux.
interface mem_read_sched_if;
  import mem_stream_pkg::*;

  logic                          start;
  logic [2:0]                    bx_in;
  logic [NPORT*NBITS_ENT-1:0]    nent;
  logic [NPORT-1:0]              rd_en;
  logic [NBITS_ENT-1:0]          rd_addr;
  logic [2:0]                    rd_bx;
  logic [3:0]                    sel;
  logic [2:0]                    bx_out;
  logic                          busy;
  logic                          trunc;

  modport master (
    output start, bx_in, nent,
    input  rd_en, rd_addr, rd_bx, sel, bx_out, busy, trunc
  );

  modport slave (
    input  start, bx_in, nent,
    output rd_en, rd_addr, rd_bx, sel, bx_out, busy, trunc
  );
endinterface

// File: rtl/mem_read_sched_nonempty_next.sv
// Finds the lowest non-empty port strictly above cur, or from port 0 when
// first is set; none flags that no such port exists.
module nonempty_next
  import mem_stream_pkg::*;
(
  input  logic [NPORT-1:0] mask,
  input  logic [PTR_W-1:0] cur,
  input  logic             first,
  output logic [PTR_W-1:0] idx,
  output logic             none
);
  always_comb begin
    idx  = '0;
    none = 1'b1;
    // Descending scan so the lowest qualifying port wins.
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (mask[i] && (first || i > int'(cur))) begin
        idx  = PTR_W'(i);
        none = 1'b0;
      end
    end
  end
endmodule

// File: rtl/mem_read_sched.sv
// Per-BX read scheduler: one header slot, then one read per clock over the
// non-empty ports, with the mux select delayed to line up with read data.
module mem_read_sched
  import mem_stream_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int MAX_SLOTS = 100
) (
  input logic             clk,
  input logic             reset_n,
  mem_read_sched_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_SLOTS + 1);

  state_t                          state;
  logic [NPORT-1:0][NBITS_ENT-1:0] nent_in, nent_q;
  logic [NPORT-1:0]                mask_in, mask_q;
  logic [PTR_W-1:0]                ptr;
  logic [NPORT-1:0]                rd_en_q;
  logic [NBITS_ENT-1:0]            addr_q;
  logic [2:0]                      rd_bx_q;
  logic [CNT_W-1:0]                slots;
  logic                            busy_q, trunc_q;
  tag_t                            iss;
  tag_t [RD_LAT-1:0]               pipe;

  assign nent_in = bus.nent;
  for (genvar p = 0; p < NPORT; p++) begin : g_mask
    assign mask_in[p] = |nent_in[p];
  end

  logic             nx_first, nx_none;
  logic [PTR_W-1:0] nx_idx;
  assign nx_first = (state == HEADER);

  nonempty_next u_next (
    .mask  (mask_q),
    .cur   (ptr),
    .first (nx_first),
    .idx   (nx_idx),
    .none  (nx_none)
  );

  logic                 port_done, go, cut;
  logic [PTR_W-1:0]     go_p;
  logic [NBITS_ENT-1:0] go_a;
  assign port_done = (addr_q == nent_q[ptr] - NBITS_ENT'(1));

  always_comb begin
    go   = 1'b0;
    go_p = ptr;
    go_a = addr_q + NBITS_ENT'(1);
    if (state == HEADER || (state == READ && port_done)) begin
      go   = !nx_none;
      go_p = nx_idx;
      go_a = '0;
    end else if (state == READ) begin
      go = 1'b1;
    end
  end
  // Only a slot that would actually be issued can exhaust the budget.
  assign cut = go && (slots == CNT_W'(MAX_SLOTS));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      nent_q  <= '0;
      mask_q  <= '0;
      ptr     <= '0;
      rd_en_q <= '0;
      addr_q  <= '0;
      rd_bx_q <= '0;
      slots   <= '0;
      busy_q  <= 1'b0;
      trunc_q <= 1'b0;
      iss     <= '0;
      pipe    <= '0;
    end else begin
      pipe[0] <= iss;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      trunc_q <= 1'b0;
      if (bus.start) begin
        // A start mid-burst abandons whatever the old BX had left.
        trunc_q <= (state != IDLE);
        state   <= HEADER;
        nent_q  <= nent_in;
        mask_q  <= mask_in;
        rd_bx_q <= bus.bx_in - 3'd1;
        iss     <= '{sel: SEL_HDR, bx: bus.bx_in - 3'd1};
        rd_en_q <= '0;
        addr_q  <= '0;
        slots   <= CNT_W'(1);
        busy_q  <= 1'b1;
      end else if (go && !cut) begin
        state   <= READ;
        ptr     <= go_p;
        addr_q  <= go_a;
        rd_en_q <= NPORT'(1) << go_p;
        iss     <= '{sel: port_to_sel(go_p), bx: rd_bx_q};
        slots   <= slots + CNT_W'(1);
        busy_q  <= 1'b1;
      end else begin
        state   <= IDLE;
        rd_en_q <= '0;
        addr_q  <= '0;
        iss     <= '0;
        busy_q  <= 1'b0;
        trunc_q <= cut;
      end
    end
  end

  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = addr_q;
  assign bus.rd_bx   = rd_bx_q;
  assign bus.sel     = pipe[RD_LAT-1].sel;
  assign bus.bx_out  = pipe[RD_LAT-1].bx;
  assign bus.busy    = busy_q;
  assign bus.trunc   = trunc_q;
endmodule
